// File: rtl/netwalk_pkg.sv
// netwalk_pkg: shared state and op encodings for the TCAM controller
package netwalk_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PROG   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_LWAIT  = 3'd3;
  localparam state_t ST_RESP   = 3'd4;
  localparam logic ADD = 1'b0;
  localparam logic DEL = 1'b1;
endpackage

// File: rtl/netwalk_free_slot_enc.sv
// netwalk_free_slot_enc: lowest-index clear bit of the valid-entry bitmap
module netwalk_free_slot_enc
  import netwalk_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 8
) (
  input  logic [N-1:0]  valid_map,
  output logic [AW-1:0] free_addr,
  output logic          none_free
);
  always_comb begin
    free_addr = '0;
    none_free = 1'b1;
    for (int i = N - 1; i >= 0; i--)
      if (!valid_map[i]) begin
        free_addr = AW'(i);
        none_free = 1'b0;
      end
  end
endmodule

// File: rtl/netwalk_tcam_ctrl.sv
// netwalk_tcam_ctrl: arbitrates control-plane add/delete and data-plane lookups onto one TCAM core
module netwalk_tcam_ctrl
  import netwalk_pkg::*;
#(
  parameter int TCAM_SIZE             = 64,
  parameter int TCAM_ADDR_WIDTH       = 8,
  parameter int DPL_MATCH_FIELD_WIDTH = 356,
  parameter int LOOKUP_LAT            = 2,
  parameter int STARVE_LIMIT          = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cp_valid,
  input  logic                             cp_op,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0] cp_data,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0] cp_mask,
  input  logic [TCAM_ADDR_WIDTH-1:0]       cp_addr,
  output logic                             cp_ready,
  output logic                             cp_done,
  output logic                             cp_err,
  output logic [TCAM_ADDR_WIDTH-1:0]       cp_result_addr,
  input  logic                             lk_valid,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0] lk_key,
  output logic                             lk_ready,
  output logic                             lk_resp_valid,
  output logic                             lk_hit,
  output logic [TCAM_ADDR_WIDTH-1:0]       lk_addr,
  output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_data,
  output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_mask,
  output logic [TCAM_ADDR_WIDTH-1:0]       tcam_program_addr,
  output logic                             tcam_program_enable,
  output logic                             tcam_delete_enable,
  output logic [DPL_MATCH_FIELD_WIDTH-1:0] of_match_field_data,
  output logic                             of_flow_found,
  input  logic                             of_match_found,
  input  logic [TCAM_ADDR_WIDTH-1:0]       of_matched_decoded_addr_out,
  output logic [TCAM_ADDR_WIDTH:0]         entry_count,
  output logic                             table_full
);
  localparam int IW = (TCAM_SIZE > 1) ? $clog2(TCAM_SIZE) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOOKUP_LAT + 1);
  localparam logic [TCAM_ADDR_WIDTH:0] SIZE_W = (TCAM_ADDR_WIDTH + 1)'(TCAM_SIZE);
  localparam logic [TCAM_SIZE-1:0] ONE = {{(TCAM_SIZE - 1){1'b0}}, 1'b1};
  state_t state;
  logic op_q;
  logic [TCAM_SIZE-1:0] valid_map;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lat_cnt;
  logic [TCAM_ADDR_WIDTH-1:0] free_addr;
  logic none_free, idle, starved, lk_grant, cp_grant, del_ok, cp_fail;
  netwalk_free_slot_enc #(.N(TCAM_SIZE), .AW(TCAM_ADDR_WIDTH)) u_enc (
    .valid_map(valid_map),
    .free_addr(free_addr),
    .none_free(none_free)
  );
  // a completion cycle is not an accept cycle, so the next request lands one cycle later
  assign idle = state == ST_IDLE && !cp_done;
  assign starved = starve_cnt == SW'(STARVE_LIMIT);
  assign lk_ready = idle && (!cp_valid || !starved);
  assign cp_ready = idle && (!lk_valid || starved);
  assign lk_grant = lk_valid && lk_ready;
  assign cp_grant = cp_valid && cp_ready;
  assign del_ok = {1'b0, cp_addr} < SIZE_W && valid_map[cp_addr[IW-1:0]];
  assign cp_fail = cp_op == ADD ? none_free : !del_ok;
  assign tcam_program_enable = state == ST_PROG;
  assign tcam_delete_enable = state == ST_PROG && op_q == DEL;
  assign of_flow_found = state == ST_LWAIT || state == ST_RESP;
  assign lk_resp_valid = state == ST_RESP;
  assign lk_hit = lk_resp_valid && of_match_found && {1'b0, of_matched_decoded_addr_out} < SIZE_W
                  && valid_map[of_matched_decoded_addr_out[IW-1:0]];
  assign lk_addr = lk_hit ? of_matched_decoded_addr_out : '0;
  assign table_full = entry_count == SIZE_W;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q <= ADD;
      valid_map <= '0;
      entry_count <= '0;
      starve_cnt <= '0;
      lat_cnt <= '0;
      cp_done <= 1'b0;
      cp_err <= 1'b0;
      cp_result_addr <= '0;
      tcam_program_data <= '0;
      tcam_program_mask <= '0;
      tcam_program_addr <= '0;
      of_match_field_data <= '0;
    end else begin
      cp_done <= 1'b0;
      cp_err <= 1'b0;
      starve_cnt <= (!cp_valid || cp_grant) ? '0 : lk_grant ? starve_cnt + 1'b1 : starve_cnt;
      if (lk_grant) begin
        of_match_field_data <= lk_key;
        lat_cnt <= '0;
        state <= ST_LWAIT;
      end else if (cp_grant && cp_fail) begin
        cp_done <= 1'b1;
        cp_err <= 1'b1;
        cp_result_addr <= '0;
      end else if (cp_grant) begin
        op_q <= cp_op;
        tcam_program_data <= cp_data;
        tcam_program_mask <= cp_mask;
        tcam_program_addr <= cp_op == ADD ? free_addr : cp_addr;
        state <= ST_PROG;
      end else if (state == ST_PROG) begin
        valid_map <= op_q == DEL ? valid_map & ~(ONE << tcam_program_addr) : valid_map | (ONE << tcam_program_addr);
        entry_count <= op_q == DEL ? entry_count - 1'b1 : entry_count + 1'b1;
        state <= ST_SETTLE;
      end else if (state == ST_SETTLE) begin
        cp_done <= 1'b1;
        cp_result_addr <= tcam_program_addr;
        state <= ST_IDLE;
      end else if (state == ST_LWAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
        state <= lat_cnt == LW'(LOOKUP_LAT - 1) ? ST_RESP : ST_LWAIT;
      end else if (state == ST_RESP) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_netwalk_tcam_ctrl.sv
// tb_netwalk_tcam_ctrl: directed bench with a TCAM core model and a flow-table scoreboard
module tb_netwalk_tcam_ctrl;
  import netwalk_pkg::*;
  localparam int W = 356;
  localparam int AW = 8;
  localparam int N = 64;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cp_valid, cp_op, cp_ready, cp_done, cp_err;
  logic [W-1:0] cp_data, cp_mask, lk_key;
  logic [AW-1:0] cp_addr, cp_result_addr, lk_addr, tcam_program_addr, of_matched_decoded_addr_out;
  logic lk_valid, lk_ready, lk_resp_valid, lk_hit;
  logic [W-1:0] tcam_program_data, tcam_program_mask, of_match_field_data;
  logic tcam_program_enable, tcam_delete_enable, of_flow_found, of_match_found;
  logic [AW:0] entry_count;
  logic table_full;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  netwalk_tcam_ctrl dut (
    .clk(clk), .reset(reset),
    .cp_valid(cp_valid), .cp_op(cp_op), .cp_data(cp_data), .cp_mask(cp_mask), .cp_addr(cp_addr),
    .cp_ready(cp_ready), .cp_done(cp_done), .cp_err(cp_err), .cp_result_addr(cp_result_addr),
    .lk_valid(lk_valid), .lk_key(lk_key), .lk_ready(lk_ready),
    .lk_resp_valid(lk_resp_valid), .lk_hit(lk_hit), .lk_addr(lk_addr),
    .tcam_program_data(tcam_program_data), .tcam_program_mask(tcam_program_mask),
    .tcam_program_addr(tcam_program_addr), .tcam_program_enable(tcam_program_enable),
    .tcam_delete_enable(tcam_delete_enable),
    .of_match_field_data(of_match_field_data), .of_flow_found(of_flow_found),
    .of_match_found(of_match_found), .of_matched_decoded_addr_out(of_matched_decoded_addr_out),
    .entry_count(entry_count), .table_full(table_full)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask
  // TCAM core model: lowest matching written entry, visible LAT cycles after the key
  logic [W-1:0] core_d[N], core_m[N];
  logic core_v[N];
  logic p_found[LAT];
  logic [AW-1:0] p_addr[LAT];
  logic cf;
  logic [AW-1:0] ca;
  always @(posedge clk) begin
    cf = 1'b0;
    ca = '0;
    for (int i = N - 1; i >= 0; i--)
      if (core_v[i] === 1'b1 && ((of_match_field_data ^ core_d[i]) & core_m[i]) == '0) begin
        cf = 1'b1;
        ca = AW'(i);
      end
    p_found[0] <= cf;
    p_addr[0] <= ca;
    for (int k = 1; k < LAT; k++) begin
      p_found[k] <= p_found[k-1];
      p_addr[k] <= p_addr[k-1];
    end
    if (reset) begin
      for (int i = 0; i < N; i++) core_v[i] <= 1'b0;
    end else if (tcam_program_enable) begin
      core_v[tcam_program_addr] <= !tcam_delete_enable;
      core_d[tcam_program_addr] <= tcam_program_data;
      core_m[tcam_program_addr] <= tcam_program_mask;
    end
  end
  assign of_match_found = p_found[LAT-1];
  assign of_matched_decoded_addr_out = p_addr[LAT-1];
  // flow-table scoreboard
  typedef struct { logic err; logic chk_addr; logic [AW-1:0] addr; int cnt; } cp_exp_t;
  typedef struct { logic [AW-1:0] addr; logic del; } wr_exp_t;
  typedef struct { logic hit; logic [AW-1:0] addr; } lk_exp_t;
  cp_exp_t q_cp[$];
  wr_exp_t q_wr[$];
  lk_exp_t q_lk[$];
  logic m_v[N];
  logic [W-1:0] m_k[N];
  int m_cnt;
  task automatic expect_cp(input logic op, input logic [W-1:0] d, input logic [AW-1:0] a);
    int s = -1;
    if (op == ADD) begin
      for (int i = N - 1; i >= 0; i--) if (!m_v[i]) s = i;
      if (s < 0) q_cp.push_back('{err: 1'b1, chk_addr: 1'b1, addr: '0, cnt: m_cnt});
      else begin
        m_v[s] = 1'b1;
        m_k[s] = d;
        m_cnt++;
        q_wr.push_back('{addr: AW'(s), del: 1'b0});
        q_cp.push_back('{err: 1'b0, chk_addr: 1'b1, addr: AW'(s), cnt: m_cnt});
      end
    end else if (int'(a) < N && m_v[a]) begin
      m_v[a] = 1'b0;
      m_cnt--;
      q_wr.push_back('{addr: a, del: 1'b1});
      q_cp.push_back('{err: 1'b0, chk_addr: 1'b1, addr: a, cnt: m_cnt});
    end else q_cp.push_back('{err: 1'b1, chk_addr: 1'b0, addr: '0, cnt: m_cnt});
  endtask
  task automatic expect_lk(input logic [W-1:0] key);
    int s = -1;
    for (int i = N - 1; i >= 0; i--) if (m_v[i] && m_k[i] == key) s = i;
    q_lk.push_back('{hit: s >= 0, addr: s >= 0 ? AW'(s) : '0});
  endtask
  logic prev_en = 1'b0;
  cp_exp_t ec;
  wr_exp_t ew;
  lk_exp_t el;
  always @(negedge clk) begin
    if (reset) prev_en = 1'b0;
    else begin
      chk("del_en_gated", tcam_delete_enable & ~tcam_program_enable, 0);
      chk("full_flag", table_full, entry_count == N);
      if (tcam_program_enable) begin
        chk("prog_pulse_1cyc", prev_en, 0);
        chk("wr_expected", q_wr.size() != 0, 1);
        if (q_wr.size() != 0) begin
          ew = q_wr.pop_front();
          chk("wr_addr", tcam_program_addr, ew.addr);
          chk("wr_del", tcam_delete_enable, ew.del);
        end
      end
      prev_en = tcam_program_enable;
      if (cp_done) begin
        chk("cp_done_expected", q_cp.size() != 0, 1);
        if (q_cp.size() != 0) begin
          ec = q_cp.pop_front();
          chk("cp_err", cp_err, ec.err);
          if (ec.chk_addr) chk("cp_result_addr", cp_result_addr, ec.addr);
          chk("entry_count", entry_count, ec.cnt);
        end
      end
      if (lk_resp_valid) begin
        chk("lk_resp_expected", q_lk.size() != 0, 1);
        if (q_lk.size() != 0) begin
          el = q_lk.pop_front();
          chk("lk_hit", lk_hit, el.hit);
          chk("lk_addr", lk_addr, el.addr);
        end
      end
    end
  end
  task automatic do_cp(input logic op, input logic [W-1:0] d, input logic [AW-1:0] a,
                       output int lat, output logic err, output logic [AW-1:0] ra);
    int t = 0;
    @(negedge clk);
    cp_valid = 1'b1; cp_op = op; cp_data = d; cp_mask = '1; cp_addr = a;
    #1;
    while (!cp_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("cp_accept", cp_ready, 1);
    expect_cp(op, d, a);
    @(posedge clk);
    #1 cp_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (cp_done) break;
    end
    chk("cp_done_seen", cp_done, 1);
    err = cp_err;
    ra = cp_result_addr;
  endtask
  task automatic do_lk(input logic [W-1:0] key, output int lat, output logic hit, output logic [AW-1:0] la);
    int t = 0;
    @(negedge clk);
    lk_valid = 1'b1; lk_key = key;
    #1;
    while (!lk_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("lk_accept", lk_ready, 1);
    expect_lk(key);
    @(posedge clk);
    #1 lk_valid = 1'b0; lk_key = '0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("of_flow_found", of_flow_found, 1);
        chk("key_held", of_match_field_data == key, 1);
      end
      if (lk_resp_valid) break;
    end
    chk("lk_resp_seen", lk_resp_valid, 1);
    hit = lk_hit;
    la = lk_addr;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, g, t, seen;
    logic err, hit;
    logic [AW-1:0] ra;
    logic [9:0] seq;
    cp_valid = 0; cp_op = 0; cp_data = '0; cp_mask = '0; cp_addr = '0; lk_valid = 0; lk_key = '0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cp_ready", cp_ready, 1);
    chk("rst_lk_ready", lk_ready, 1);
    chk("rst_cp_done", cp_done, 0);
    chk("rst_lk_resp", lk_resp_valid, 0);
    chk("rst_prog_en", tcam_program_enable, 0);
    chk("rst_del_en", tcam_delete_enable, 0);
    chk("rst_flow_found", of_flow_found, 0);
    chk("rst_count", entry_count, 0);
    chk("rst_full", table_full, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cp(ADD, W'(64'h100 + i), '0, lat, err, ra);
      chk("add_slot", ra, i);
      chk("add_lat", lat, 3);
      chk("add_err", err, 0);
    end
    chk("count_3", entry_count, 3);
    do_lk(W'(64'h101), lat, hit, ra);
    chk("lk_lat", lat, 3);
    chk("lk_hit_1", hit, 1);
    chk("lk_addr_1", ra, 1);
    do_lk(W'(64'hdead), lat, hit, ra);
    chk("lk_miss_hit", hit, 0);
    chk("lk_miss_addr", ra, 0);
    do_cp(DEL, '0, 8'd1, lat, err, ra);
    chk("del1_err", err, 0);
    chk("del1_addr", ra, 1);
    chk("del1_lat", lat, 3);
    do_cp(ADD, W'(64'h103), '0, lat, err, ra);
    chk("readd_slot", ra, 1);
    do_cp(DEL, '0, 8'd1, lat, err, ra);
    chk("del1b_err", err, 0);
    do_cp(DEL, '0, 8'd1, lat, err, ra);
    chk("del_twice_err", err, 1);
    chk("del_twice_lat", lat, 1);
    // both requesters held high: four lookups, then one control grant
    @(negedge clk);
    lk_key = W'(64'h102); cp_op = ADD; cp_data = W'(64'h55); cp_mask = '1; lk_valid = 1; cp_valid = 1;
    g = 0; seq = '0; t = 0;
    while (g < 10 && t < 400) begin
      #1;
      chk("ready_exclusive", lk_ready & cp_ready, 0);
      if (lk_ready) begin
        expect_lk(W'(64'h102));
        seq = {seq[8:0], 1'b0};
        g++;
      end else if (cp_ready) begin
        expect_cp(ADD, W'(64'h55), '0);
        seq = {seq[8:0], 1'b1};
        g++;
      end
      if (g == 10) begin
        @(posedge clk);
        #1 lk_valid = 0; cp_valid = 0;
      end else @(negedge clk);
      t++;
    end
    chk("starve_pattern", seq, 10'b0000100001);
    repeat (8) @(negedge clk);
    for (int i = 0; i < N && m_cnt < N; i++) do_cp(ADD, W'(64'h2000 + i), '0, lat, err, ra);
    chk("fill_last_slot", ra, 63);
    chk("fill_full", table_full, 1);
    chk("fill_count", entry_count, 64);
    do_cp(ADD, W'(64'h3000), '0, lat, err, ra);
    chk("full_add_err", err, 1);
    chk("full_add_lat", lat, 1);
    chk("full_add_addr", ra, 0);
    do_cp(DEL, '0, 8'd200, lat, err, ra);
    chk("del_oor_err", err, 1);
    do_cp(DEL, '0, 8'd5, lat, err, ra);
    chk("del5_addr", ra, 5);
    // reset lands while the add is in PROG
    @(negedge clk);
    cp_valid = 1; cp_op = ADD; cp_data = W'(64'h77); cp_mask = '1;
    #1;
    chk("prog_accept", cp_ready, 1);
    expect_cp(ADD, W'(64'h77), '0);
    @(posedge clk);
    #1 cp_valid = 0;
    @(negedge clk);
    chk("in_prog", tcam_program_enable, 1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_prog_en", tcam_program_enable, 0);
    chk("abort_del_en", tcam_delete_enable, 0);
    chk("abort_count", entry_count, 0);
    chk("abort_full", table_full, 0);
    q_cp.delete(); q_wr.delete(); q_lk.delete();
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(cp_done);
    end
    chk("no_done_after_abort", seen, 0);
    do_cp(ADD, W'(64'h88), '0, lat, err, ra);
    chk("post_reset_slot", ra, 0);
    chk("post_reset_count", entry_count, 1);
    repeat (4) @(negedge clk);
    chk("queues_drained", q_cp.size() + q_wr.size() + q_lk.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
